// File: rtl/encrypt_store_pkg.sv
// Shared types and helpers for the rotate-multiply-store engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package encrypt_store_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    STORE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_RW    = $clog2(DEF_WIDTH);
  localparam int DEF_AW    = $clog2(DEF_DEPTH);

  // Rotate the low w bits of v right by amt; bits above w are returned as 0.
  // Operands up to 32 bits wide are supported.
  function automatic logic [31:0] rotr(input logic [31:0] v, input logic [4:0] amt,
                                       input int unsigned w);
    logic [31:0] mask;
    logic [31:0] lo;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    lo   = v & mask;
    // amt == 0 shifts the copy by w, which the mask then discards
    return ((lo >> amt) | (lo << (w - 32'(amt)))) & mask;
  endfunction

endpackage

// File: rtl/seq_shift_add_mul.sv
// Unsigned shift-add multiplier, one multiplier bit retired per cycle.
// Latency: WIDTH cycles from start; last flags the cycle whose edge completes it.
// Backpressure: none; start is ignored while busy, abort cancels immediately.
module seq_shift_add_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 abort,
  input  logic                 start,
  input  logic [WIDTH-1:0]     m_in,
  input  logic [WIDTH-1:0]     q_in,
  output logic                 busy,
  output logic                 last,
  output logic [2*WIDTH-1:0]   prod_nxt
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic             c;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   ca;

  // Conditional add of M into {C,A}; the shift is folded into the register update
  always_comb begin
    ca = {c, a};
    if (q[0]) ca = {1'b0, a} + {1'b0, m};
  end

  // {C,A,Q} after this cycle's add-and-shift, i.e. the product once the counter expires
  assign prod_nxt = {ca[WIDTH:1], ca[0], q[WIDTH-1:1]};
  assign last     = busy && (cnt == CW'(1));

  // Operand load, per-bit add/shift and bit counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m    <= '0;
      a    <= '0;
      q    <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start && !busy) begin
      m    <= m_in;
      q    <= q_in;
      a    <= '0;
      c    <= 1'b0;
      cnt  <= CW'(WIDTH);
      busy <= 1'b1;
    end else if (busy) begin
      c   <= 1'b0;
      a   <= ca[WIDTH:1];
      q   <= {ca[0], q[WIDTH-1:1]};
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/encrypt_store_engine.sv
// Rotates num right, multiplies by key and stores the product at an auto-incrementing address.
// Latency: done pulses WIDTH cycles after accept; next accept possible WIDTH+2 cycles after accept.
// Backpressure: in_ready low while busy, and (WRAP=0) once the buffer is full until clr/reset.
module encrypt_store_engine
  import encrypt_store_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int WRAP  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           num,
  input  logic [WIDTH-1:0]           key,
  input  logic [$clog2(WIDTH)-1:0]   rot_amt,
  output logic                       done,
  output logic [2*WIDTH-1:0]         result,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic                       full,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [2*WIDTH-1:0]         rd_data
);

  localparam int AW = $clog2(DEPTH);

  state_t               state;
  logic [AW:0]          count;
  logic                 accept;
  logic                 mul_busy;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   mul_prod;
  logic [WIDTH-1:0]     num_rot;
  logic [2*WIDTH-1:0]   mem [DEPTH];

  assign full     = (count == (AW+1)'(DEPTH));
  assign in_ready = (state == IDLE) && (!full || (WRAP != 0));
  // clr wins over a simultaneous accept
  assign accept   = in_valid && in_ready && !clr;
  assign num_rot  = WIDTH'(rotr(32'(num), 5'(rot_amt), WIDTH));

  seq_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (clr),
    .start    (accept),
    .m_in     (num_rot),
    .q_in     (key),
    .busy     (mul_busy),
    .last     (mul_last),
    .prod_nxt (mul_prod)
  );

  // Control FSM with registered done/result, write pointer and occupancy count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      count  <= '0;
      done   <= 1'b0;
      result <= '0;
    end else if (clr) begin
      state  <= IDLE;
      wr_ptr <= '0;
      count  <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= MUL;
        end
        MUL: begin
          if (mul_last) begin
            result <= mul_prod;
            done   <= 1'b1;
            state  <= STORE;
          end else if (!mul_busy) begin
            state <= IDLE;
          end
        end
        STORE: begin
          done   <= 1'b0;
          wr_ptr <= wr_ptr + AW'(1);
          if (!full) count <= count + (AW+1)'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result buffer write; contents survive reset and clr
  always_ff @(posedge clk) begin
    if (rst_n && !clr && (state == STORE)) mem[wr_ptr] <= result;
  end

  // Registered read port; a same-edge write to the same address is not visible yet
  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_encrypt_store_engine.sv
module tb_encrypt_store_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // shared reset
  logic rst_n;

  // main instance: WIDTH=4, DEPTH=16, WRAP=0
  logic       clr, in_valid, rd_en;
  logic [3:0] num, key, rd_addr;
  logic [1:0] rot_amt;
  logic       in_ready, done, full;
  logic [7:0] result, rd_data;
  logic [3:0] wr_ptr;

  // small instances: DEPTH=4, WRAP=0 (b) and WRAP=1 (c), shared stimulus
  logic       s_clr, s_in_valid, s_rd_en;
  logic [3:0] s_num, s_key;
  logic [1:0] s_rot, s_rd_addr;
  logic       b_ready, b_done, b_full, c_ready, c_done, c_full;
  logic [7:0] b_result, b_rd, c_result, c_rd;
  logic [1:0] b_wr_ptr, c_wr_ptr;

  logic [3:0] vn [4] = '{4'b1000, 4'b1001, 4'b1100, 4'b1011};
  logic [3:0] vk [4] = '{4'b1000, 4'b1000, 4'b1010, 4'b1110};
  logic [7:0] ve [4] = '{8'h10, 8'h30, 8'h1E, 8'hC4};

  encrypt_store_engine #(.WIDTH(4), .DEPTH(16), .WRAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .num(num), .key(key), .rot_amt(rot_amt), .done(done), .result(result),
    .wr_ptr(wr_ptr), .full(full), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  encrypt_store_engine #(.WIDTH(4), .DEPTH(4), .WRAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .in_valid(s_in_valid), .in_ready(b_ready),
    .num(s_num), .key(s_key), .rot_amt(s_rot), .done(b_done), .result(b_result),
    .wr_ptr(b_wr_ptr), .full(b_full), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(b_rd)
  );

  encrypt_store_engine #(.WIDTH(4), .DEPTH(4), .WRAP(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .in_valid(s_in_valid), .in_ready(c_ready),
    .num(s_num), .key(s_key), .rot_amt(s_rot), .done(c_done), .result(c_result),
    .wr_ptr(c_wr_ptr), .full(c_full), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(c_rd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one pair into the main instance; returns in the STORE cycle (done high)
  task automatic m_op(input logic [3:0] n, input logic [3:0] k, input logic [1:0] r,
                      input logic [7:0] exp, input logic [3:0] addr, input string tag);
    int g;
    int lat;
    num = n; key = k; rot_amt = r; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin step(); g++; end
    chk({tag, " ready"}, 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin step(); lat++; end
    chk({tag, " latency"}, lat, 4);
    chk({tag, " result"}, result, exp);
    chk({tag, " addr"}, wr_ptr, addr);
  endtask

  // Drive one pair into both small instances and let it complete
  task automatic s_op(input logic [3:0] n, input logic [3:0] k, input logic [1:0] r);
    int g;
    s_num = n; s_key = k; s_rot = r; s_in_valid = 1'b1;
    g = 0;
    while (!c_ready && g < 50) begin step(); g++; end
    chk("s_op ready", 32'(c_ready), 1);
    step();
    s_in_valid = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    int b_seen;
    int c_seen;
    int seen;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
    num = '0; key = '0; rot_amt = '0; rd_addr = '0;
    s_clr = 1'b0; s_in_valid = 1'b0; s_rd_en = 1'b0;
    s_num = '0; s_key = '0; s_rot = '0; s_rd_addr = '0;
    step(); step();
    chk("rst done", 32'(done), 0);
    chk("rst result", result, 0);
    chk("rst wr_ptr", wr_ptr, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst full", 32'(full), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    // four directed pairs, rot_amt=2
    for (int i = 0; i < 4; i++) begin
      m_op(vn[i], vk[i], 2'd2, ve[i], 4'(i), $sformatf("op%0d", i));
      step();
    end
    chk("wr_ptr after 4", wr_ptr, 4);

    // read-back
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      step();
      chk($sformatf("read%0d", i), rd_data, ve[i]);
    end
    rd_en = 1'b0; rd_addr = 4'd0;
    step();
    chk("read hold", rd_data, 8'hC4);

    // carry path and zero operand
    m_op(4'b1111, 4'b1111, 2'd0, 8'hE1, 4'd4, "carry");
    step();
    m_op(4'b0000, 4'b1011, 2'd2, 8'h00, 4'd5, "zero");
    step();

    // clr in IDLE, then same-address read on the STORE edge
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr wr_ptr", wr_ptr, 0);
    chk("clr in_ready", 32'(in_ready), 1);
    m_op(4'b0011, 4'b0101, 2'd1, 8'h2D, 4'd0, "rot1");
    rd_en = 1'b1; rd_addr = 4'd0;
    step();
    chk("same-addr old", rd_data, 8'h10);
    step();
    chk("same-addr new", rd_data, 8'h2D);
    rd_en = 1'b0;
    chk("wr_ptr after rot1", wr_ptr, 1);

    // clr two edges after accept
    num = 4'b1011; key = 4'b1110; rot_amt = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    clr = 1'b1; step(); clr = 1'b0;
    chk("abort wr_ptr", wr_ptr, 0);
    chk("abort in_ready", 32'(in_ready), 1);
    chk("abort result kept", result, 8'h2D);
    seen = 0;
    repeat (6) begin step(); if (done) seen++; end
    chk("abort no done", seen, 0);
    rd_en = 1'b1; rd_addr = 4'd1;
    step();
    chk("abort no write", rd_data, 8'h30);
    rd_en = 1'b0;
    m_op(4'b1000, 4'b1000, 2'd2, 8'h10, 4'd0, "post-abort");
    step();

    // reset during STORE
    m_op(4'b1100, 4'b1010, 2'd2, 8'h1E, 4'd1, "pre-reset");
    rst_n = 1'b0;
    step();
    chk("rstS done", 32'(done), 0);
    chk("rstS result", result, 0);
    chk("rstS wr_ptr", wr_ptr, 0);
    chk("rstS rd_data", rd_data, 0);
    chk("rstS full", 32'(full), 0);
    rst_n = 1'b1;
    step();
    chk("rstS in_ready", 32'(in_ready), 1);
    rd_en = 1'b1; rd_addr = 4'd1;
    step();
    chk("rstS no write", rd_data, 8'h30);
    rd_en = 1'b0;

    // full handling on DEPTH=4 instances
    for (int i = 0; i < 4; i++) s_op(vn[i], vk[i], 2'd2);
    chk("b full", 32'(b_full), 1);
    chk("b in_ready", 32'(b_ready), 0);
    chk("b wr_ptr", b_wr_ptr, 0);
    chk("c full", 32'(c_full), 1);
    chk("c in_ready", 32'(c_ready), 1);
    s_num = 4'b1111; s_key = 4'b1111; s_rot = 2'd0; s_in_valid = 1'b1;
    b_seen = 0; c_seen = 0;
    repeat (6) begin
      step();
      if (b_done) b_seen++;
      if (c_done) c_seen++;
    end
    s_in_valid = 1'b0;
    chk("b no accept", b_seen, 0);
    chk("c fifth done", c_seen, 1);
    chk("b still blocked", 32'(b_ready), 0);
    s_rd_en = 1'b1; s_rd_addr = 2'd0;
    step();
    chk("c overwrite0", c_rd, 8'hE1);
    chk("b kept0", b_rd, 8'h10);
    s_rd_addr = 2'd1;
    step();
    chk("c kept1", c_rd, 8'h30);
    s_rd_en = 1'b0;
    s_clr = 1'b1; step(); s_clr = 1'b0;
    chk("b clr in_ready", 32'(b_ready), 1);
    chk("b clr wr_ptr", b_wr_ptr, 0);
    chk("b clr full", 32'(b_full), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
